instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader_if.sv | 25 ++
 rtl/instr_loader.sv | 117 +++++++++++
 tb/tb_instr_loader.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_loader_if.sv
// Byte-stream and instruction-memory port bundle for instr_loader.
// master drives the program byte stream; slave is the loader itself.
interface instr_loader_if #(
  parameter int ADDR_W = 5
);
  logic [7:0]        IN_DATA;
  logic              IN_VALID;
  logic              IN_READY;
  logic              IM_WE;
  logic [ADDR_W-1:0] IM_ADDR;
  logic [31:0]       IM_WDATA;
  logic              START;
  logic              BUSY;
  logic              ERR;

  modport master (
    output IN_DATA, IN_VALID,
    input  IN_READY, IM_WE, IM_ADDR, IM_WDATA, START, BUSY, ERR
  );

  modport slave (
    input  IN_DATA, IN_VALID,
    output IN_READY, IM_WE, IM_ADDR, IM_WDATA, START, BUSY, ERR
  );
endinterface

// File: rtl/instr_loader.sv
// Boot loader: header byte N, then N big-endian 32-bit words written to instruction memory.
// Define INSTR_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte (CHK state).
module instr_loader #(
  parameter int ADDR_W = 5
) (
  input logic           CLK,
  input logic           RST_N,
  instr_loader_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

`ifdef INSTR_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, CHK, DONE, FAIL} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE, FAIL} state_t;
`endif

  state_t            state;
  logic [1:0]        byte_cnt;
  logic [ADDR_W-1:0] word_idx;
  logic [ADDR_W-1:0] last_idx;
  logic [23:0]       asm_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif
  logic              xfer;
  logic [31:0]       hdr_n;

  assign xfer  = bus.IN_VALID && bus.IN_READY;
  assign hdr_n = {24'd0, bus.IN_DATA};

  // All outputs are registered; IM_WE defaults low so each write is a single-cycle pulse.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= IDLE;
      byte_cnt     <= 2'd0;
      word_idx     <= '0;
      last_idx     <= '0;
      asm_q        <= 24'd0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum         <= 8'd0;
`endif
      bus.IN_READY <= 1'b0;
      bus.IM_WE    <= 1'b0;
      bus.IM_ADDR  <= '0;
      bus.IM_WDATA <= 32'd0;
      bus.START    <= 1'b0;
      bus.BUSY     <= 1'b0;
      bus.ERR      <= 1'b0;
    end else begin
      bus.IM_WE <= 1'b0;
      case (state)
        IDLE: begin
          bus.IN_READY <= 1'b1;
          if (xfer) begin
            if (hdr_n == 32'd0 || hdr_n > 32'(DEPTH)) begin
              state        <= FAIL;
              bus.IN_READY <= 1'b0;
              bus.ERR      <= 1'b1;
            end else begin
              state    <= LOAD;
              bus.BUSY <= 1'b1;
              last_idx <= ADDR_W'(hdr_n - 32'd1);
            end
          end
        end

        LOAD: begin
          if (xfer) begin
            asm_q    <= {asm_q[15:0], bus.IN_DATA};
            byte_cnt <= byte_cnt + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum     <= csum ^ bus.IN_DATA;
`endif
            // Fourth byte completes a word: the write goes out on the following cycle.
            if (byte_cnt == 2'd3) begin
              bus.IM_WE    <= 1'b1;
              bus.IM_ADDR  <= word_idx;
              bus.IM_WDATA <= {asm_q, bus.IN_DATA};
              word_idx     <= word_idx + 1'b1;
              if (word_idx == last_idx) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                state        <= CHK;
`else
                state        <= DONE;
                bus.BUSY     <= 1'b0;
                bus.IN_READY <= 1'b0;
                bus.START    <= 1'b1;
`endif
              end
            end
          end
        end

`ifdef INSTR_LOADER_CHECKSUM_EN
        CHK: begin
          if (xfer) begin
            bus.BUSY     <= 1'b0;
            bus.IN_READY <= 1'b0;
            if (bus.IN_DATA == csum) begin
              state     <= DONE;
              bus.START <= 1'b1;
            end else begin
              state   <= FAIL;
              bus.ERR <= 1'b1;
            end
          end
        end
`endif

        DONE, FAIL: ;

        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: table-driven load vectors plus reset/checksum sequences.
// Build with INSTR_LOADER_CHECKSUM_EN to exercise the checksum variant.
module tb_instr_loader;
  localparam int ADDR_W = 5;

  logic CLK = 1'b0;
  logic RST_N;
  int   tests = 0;
  int   fails = 0;

  always #5 CLK = ~CLK;

  instr_loader_if #(.ADDR_W(ADDR_W)) bus ();

  instr_loader #(.ADDR_W(ADDR_W)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic              start;
  } wr_t;

  typedef struct {
    string       name;
    logic [7:0]  hdr;
    logic [31:0] base;
    logic [31:0] step;
    bit          gap;
    bit          exp_err;
  } vec_t;

  wr_t  wr_q[$];
  vec_t vecs[7];

  // Every memory write strobe seen by the bench, sampled mid-cycle.
  always @(negedge CLK)
    if (bus.IM_WE === 1'b1)
      wr_q.push_back('{addr: bus.IM_ADDR, data: bus.IM_WDATA, start: bus.START});

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit acc;
    acc = 1'b0;
    bus.IN_DATA  = b;
    bus.IN_VALID = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge CLK);
      acc = bus.IN_READY;
      @(posedge CLK);
      #1;
    end
    bus.IN_VALID = 1'b0;
    checkOutput($sformatf("accept_%h", b), {31'd0, acc}, 32'd1);
    if (gap) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checkOutput({tag, "_ready"}, {31'd0, bus.IN_READY}, 32'd0);
    checkOutput({tag, "_we"},    {31'd0, bus.IM_WE},    32'd0);
    checkOutput({tag, "_addr"},  32'(bus.IM_ADDR),      32'd0);
    checkOutput({tag, "_wdata"}, bus.IM_WDATA,          32'd0);
    checkOutput({tag, "_start"}, {31'd0, bus.START},    32'd0);
    checkOutput({tag, "_busy"},  {31'd0, bus.BUSY},     32'd0);
    checkOutput({tag, "_err"},   {31'd0, bus.ERR},      32'd0);
  endtask

  task automatic do_reset();
    bus.IN_VALID = 1'b0;
    bus.IN_DATA  = 8'd0;
    RST_N = 1'b0;
    @(negedge CLK);
    #1;
    check_idle_outputs("rst");
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    checkOutput("ready_before_edge", {31'd0, bus.IN_READY}, 32'd0);
    @(posedge CLK);
    #1;
    checkOutput("ready_after_edge", {31'd0, bus.IN_READY}, 32'd1);
  endtask

  // Streams one load (header, payload and, when compiled in, the XOR checksum) and checks the result.
  task automatic run_load(input vec_t v);
    int          n;
    logic [31:0] w;
    logic [7:0]  cs;
    cs = 8'd0;
    wr_q.delete();
    send_byte(v.hdr, v.gap);
    checkOutput({v.name, "_busy_hdr"}, {31'd0, bus.BUSY}, {31'd0, !v.exp_err});
    n = v.exp_err ? 0 : int'(v.hdr);
    for (int k = 0; k < n; k++) begin
      w = v.base + 32'(k) * v.step;
      for (int b = 0; b < 4; b++) begin
        cs = cs ^ w[31-8*b -: 8];
        send_byte(w[31-8*b -: 8], v.gap);
      end
    end
`ifdef INSTR_LOADER_CHECKSUM_EN
    if (!v.exp_err) send_byte(cs, v.gap);
`endif
    repeat (3) @(posedge CLK);
    #1;
    checkOutput({v.name, "_nwrites"}, 32'(wr_q.size()), 32'(n));
    for (int i = 0; i < n && i < wr_q.size(); i++) begin
      w = v.base + 32'(i) * v.step;
      checkOutput($sformatf("%s_addr%0d", v.name, i), 32'(wr_q[i].addr), 32'(i));
      checkOutput($sformatf("%s_data%0d", v.name, i), wr_q[i].data, w);
`ifdef INSTR_LOADER_CHECKSUM_EN
      checkOutput($sformatf("%s_start_at_wr%0d", v.name, i), {31'd0, wr_q[i].start}, 32'd0);
`else
      checkOutput($sformatf("%s_start_at_wr%0d", v.name, i), {31'd0, wr_q[i].start},
                  {31'd0, (i == n - 1)});
`endif
    end
    checkOutput({v.name, "_err"},   {31'd0, bus.ERR},      {31'd0, v.exp_err});
    checkOutput({v.name, "_start"}, {31'd0, bus.START},    {31'd0, !v.exp_err});
    checkOutput({v.name, "_busy"},  {31'd0, bus.BUSY},     32'd0);
    checkOutput({v.name, "_ready"}, {31'd0, bus.IN_READY}, 32'd0);
    checkOutput({v.name, "_we"},    {31'd0, bus.IM_WE},    32'd0);
    checkOutput({v.name, "_addr_hold"}, 32'(bus.IM_ADDR), (n > 0) ? 32'(n - 1) : 32'd0);
    checkOutput({v.name, "_wdata_hold"}, bus.IM_WDATA,
                (n > 0) ? v.base + 32'(n - 1) * v.step : 32'd0);
  endtask

  task automatic applyStimulus(input vec_t v);
    do_reset();
    run_load(v);
  endtask

`ifdef INSTR_LOADER_CHECKSUM_EN
  // 01, 11 22 33 44, then checksum byte; the XOR of the payload is 0x44.
  task automatic checksum_seq(input logic [7:0] cs, input bit exp_err);
    logic [7:0] payload [4];
    payload = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    wr_q.delete();
    send_byte(8'h01, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(payload[i], 1'b0);
    checkOutput("cs_busy_in_chk", {31'd0, bus.BUSY}, 32'd1);
    send_byte(cs, 1'b0);
    checkOutput($sformatf("cs%h_start", cs), {31'd0, bus.START}, {31'd0, !exp_err});
    checkOutput($sformatf("cs%h_err", cs),   {31'd0, bus.ERR},   {31'd0, exp_err});
    checkOutput($sformatf("cs%h_ready", cs), {31'd0, bus.IN_READY}, 32'd0);
    checkOutput($sformatf("cs%h_nwrites", cs), 32'(wr_q.size()), 32'd1);
  endtask
`endif

  initial begin
    vec_t one;
    RST_N        = 1'b0;
    bus.IN_VALID = 1'b0;
    bus.IN_DATA  = 8'd0;

    vecs[0] = '{"one_word",    8'h01, 32'h0022_0820, 32'h0000_0000, 1'b0, 1'b0};
    vecs[1] = '{"two_gapped",  8'h02, 32'hA1B2_C3D4, 32'h1234_5678, 1'b1, 1'b0};
    vecs[2] = '{"hdr_zero",    8'h00, 32'h0,         32'h0,         1'b0, 1'b1};
    vecs[3] = '{"hdr_33",      8'h21, 32'h0,         32'h0,         1'b0, 1'b1};
    vecs[4] = '{"three_words", 8'h03, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 1'b0};
    vecs[5] = '{"full_depth",  8'h20, 32'h1020_3040, 32'h0101_0101, 1'b0, 1'b0};
    vecs[6] = '{"hdr_ff",      8'hFF, 32'h0,         32'h0,         1'b1, 1'b1};

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    // Reset mid-load after 6 of 8 payload bytes: only the first word may have been written.
    do_reset();
    wr_q.delete();
    send_byte(8'h02, 1'b0);
    for (int b = 1; b <= 6; b++) send_byte(8'(b), 1'b0);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check_idle_outputs("midrst");
    checkOutput("midrst_nwrites", 32'(wr_q.size()), 32'd1);
    if (wr_q.size() > 0) checkOutput("midrst_word0", wr_q[0].data, 32'h0102_0304);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    checkOutput("midrst_nwrites_after", 32'(wr_q.size()), 32'd1);
    one = '{"reload", 8'h01, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0};
    run_load(one);

`ifdef INSTR_LOADER_CHECKSUM_EN
    checksum_seq(8'h45, 1'b1);
    checksum_seq(8'h44, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
